// File: rtl/serial_symbol_decoder_if.sv
// Interface bundle for serial_symbol_decoder: serial line in, decoded symbol
// handshake and status out. master = line/consumer side, slave = decoder.
interface serial_symbol_decoder_if #(
   parameter int DATA_W = 4
) ();
   logic              signal;
   logic              gray_mode;
   logic              dready;
   logic [DATA_W-1:0] dout;
   logic              dvalid;
   logic              code_err;
   logic              frame_err;
   logic              par_err;
   logic              ovr;
   logic              busy;

   modport master (
      output signal, gray_mode, dready,
      input  dout, dvalid, code_err, frame_err, par_err, ovr, busy
   );

   modport slave (
      input  signal, gray_mode, dready,
      output dout, dvalid, code_err, frame_err, par_err, ovr, busy
   );
endinterface

// File: rtl/serial_symbol_decoder.sv
// Framed serial symbol receiver with mid-bit sampling, binary/Gray decode and
// range check. Optional parity bit enabled by macro SERIAL_SYMBOL_PARITY_EN.
module serial_symbol_decoder #(
   parameter int CLK_DIV     = 500000,
   parameter int DATA_W      = 4,
   parameter int MAX_CODE    = 9,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   serial_symbol_decoder_if.slave  bus
);
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic [31:0]      MAX_CODE_W = 32'(MAX_CODE);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic [DATA_W-1:0] gray_to_bin(input logic [DATA_W-1:0] g);
      logic [DATA_W-1:0] b;
      b[DATA_W-1] = g[DATA_W-1];
      for (int i = DATA_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_s;
   logic                   s_prev_r;
   logic                   rise_s;
   state_t                 state_r, state_nxt;
   logic [CNT_W-1:0]       cnt_r, cnt_nxt;
   logic [IDX_W-1:0]       idx_r, idx_nxt;
   logic [DATA_W-1:0]      shift_r, shift_nxt;
   logic                   gray_r, gray_nxt;
   logic                   stop_done_s;
   logic                   stop_bit_s;
   logic                   load_s;
   logic [DATA_W-1:0]      dec_s;
   logic                   code_err_s;
   logic                   par_err_s;
   logic [DATA_W-1:0]      dout_r;
   logic                   dvalid_r;
   logic                   code_err_r;
   logic                   frame_err_r;
   logic                   par_err_r;
   logic                   ovr_r;
   logic                   busy_r;
`ifdef SERIAL_SYMBOL_PARITY_EN
   logic                   par_bit_r, par_bit_nxt;
`endif

   assign s_s    = sync_r[SYNC_STAGES-1];
   assign rise_s = s_s & ~s_prev_r;

   // Input synchroniser and previous-value flop for start-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r   <= {SYNC_STAGES{1'b0}};
         s_prev_r <= 1'b0;
      end else begin
         sync_r   <= {sync_r[SYNC_STAGES-2:0], bus.signal};
         s_prev_r <= s_s;
      end
   end

   // Frame FSM state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         idx_r     <= {IDX_W{1'b0}};
         shift_r   <= {DATA_W{1'b0}};
         gray_r    <= 1'b0;
`ifdef SERIAL_SYMBOL_PARITY_EN
         par_bit_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_nxt;
         cnt_r     <= cnt_nxt;
         idx_r     <= idx_nxt;
         shift_r   <= shift_nxt;
         gray_r    <= gray_nxt;
`ifdef SERIAL_SYMBOL_PARITY_EN
         par_bit_r <= par_bit_nxt;
`endif
      end
   end

   // Next-state logic: every bit is sampled when the baud counter reaches zero.
   always_comb begin
      state_nxt   = state_r;
      cnt_nxt     = cnt_r;
      idx_nxt     = idx_r;
      shift_nxt   = shift_r;
      gray_nxt    = gray_r;
      stop_done_s = 1'b0;
      stop_bit_s  = 1'b0;
`ifdef SERIAL_SYMBOL_PARITY_EN
      par_bit_nxt = par_bit_r;
`endif
      case (state_r)
         IDLE: begin
            if (rise_s) begin
               state_nxt = START;
               cnt_nxt   = CNT_HALF;
            end else begin
               cnt_nxt   = {CNT_W{1'b0}};
            end
         end
         START: begin
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_nxt = cnt_r - CNT_W'(1);
            end else if (s_s) begin
               state_nxt = DATA;
               gray_nxt  = bus.gray_mode;
               idx_nxt   = {IDX_W{1'b0}};
               cnt_nxt   = CNT_FULL;
            end else begin
               state_nxt = IDLE;
            end
         end
         DATA: begin
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_nxt = cnt_r - CNT_W'(1);
            end else begin
               shift_nxt = {shift_r[DATA_W-2:0], s_s};
               cnt_nxt   = CNT_FULL;
               if (idx_r == IDX_LAST) begin
                  idx_nxt = {IDX_W{1'b0}};
`ifdef SERIAL_SYMBOL_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  idx_nxt = idx_r + IDX_W'(1);
               end
            end
         end
`ifdef SERIAL_SYMBOL_PARITY_EN
         PARITY: begin
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_nxt = cnt_r - CNT_W'(1);
            end else begin
               par_bit_nxt = s_s;
               cnt_nxt     = CNT_FULL;
               state_nxt   = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_nxt = cnt_r - CNT_W'(1);
            end else begin
               stop_done_s = 1'b1;
               stop_bit_s  = s_s;
               state_nxt   = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   assign dec_s      = gray_r ? gray_to_bin(shift_r) : shift_r;
   assign code_err_s = 32'(dec_s) > MAX_CODE_W;
`ifdef SERIAL_SYMBOL_PARITY_EN
   assign par_err_s  = ^{shift_r, par_bit_r};
`else
   assign par_err_s  = 1'b0;
`endif
   // A completed symbol is accepted only if the output slot is free or draining.
   assign load_s = stop_done_s & (~dvalid_r | bus.dready);

   // Output holding register with valid/ready handshake and overrun pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_r      <= {DATA_W{1'b0}};
         dvalid_r    <= 1'b0;
         code_err_r  <= 1'b0;
         frame_err_r <= 1'b0;
         par_err_r   <= 1'b0;
         ovr_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         ovr_r  <= stop_done_s & dvalid_r & ~bus.dready;
         busy_r <= (state_nxt != IDLE);
         if (load_s) begin
            dout_r      <= dec_s;
            code_err_r  <= code_err_s;
            frame_err_r <= stop_bit_s;
            par_err_r   <= par_err_s;
            dvalid_r    <= 1'b1;
         end else if (dvalid_r && bus.dready) begin
            dvalid_r    <= 1'b0;
         end else begin
            dvalid_r    <= dvalid_r;
         end
      end
   end

   assign bus.dout      = dout_r;
   assign bus.dvalid    = dvalid_r;
   assign bus.code_err  = code_err_r & dvalid_r;
   assign bus.frame_err = frame_err_r & dvalid_r;
   assign bus.par_err   = par_err_r & dvalid_r;
   assign bus.ovr       = ovr_r;
   assign bus.busy      = busy_r;
endmodule

// File: tb/tb_serial_symbol_decoder.sv
// Randomized self-checking bench for serial_symbol_decoder against a
// frame-level reference model (Gray decode by prefix XOR, range/parity rules).
module tb_serial_symbol_decoder;
   localparam int CLK_DIV     = 8;
   localparam int DATA_W      = 4;
   localparam int MAX_CODE    = 9;
   localparam int SYNC_STAGES = 2;
`ifdef SERIAL_SYMBOL_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   ovr_cnt;
   int   dv_cycles;
   logic [DATA_W+2:0] obs_q[$];
   bit   tx_q[$];

   serial_symbol_decoder_if #(.DATA_W(DATA_W)) bus ();

   serial_symbol_decoder #(
      .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .MAX_CODE(MAX_CODE), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: record accepted symbols, overrun pulses and valid-high cycles.
   always @(negedge clk) begin
      if (rst_n && bus.dvalid && bus.dready)
         obs_q.push_back({bus.code_err, bus.frame_err, bus.par_err, bus.dout});
      if (bus.ovr) ovr_cnt++;
      if (bus.dvalid) dv_cycles++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_decode(input int raw, input bit gray);
      int b = 0;
      int g = raw;
      if (!gray) return raw;
      while (g != 0) begin
         b = b ^ g;
         g = g >> 1;
      end
      return b;
   endfunction

   task automatic drive_bits();
      foreach (tx_q[i]) begin
         bus.signal = tx_q[i];
         repeat (CLK_DIV) @(posedge clk);
         #1;
      end
      bus.signal = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int raw, input bit gray, input bit stop_bit, input bit par_bit);
      bus.gray_mode = gray;
      tx_q.delete();
      tx_q.push_back(1'b1);
      for (int i = DATA_W - 1; i >= 0; i--) tx_q.push_back(((raw >> i) & 1) != 0);
      if (PAR_EN) tx_q.push_back(par_bit);
      tx_q.push_back(stop_bit);
      drive_bits();
   endtask

   task automatic run_symbol(input int raw, input bit gray, input bit stop_bit, input bit par_bit);
      int exp_val;
      int dv0;
      logic [DATA_W+2:0] o;
      bit par_odd;
      exp_val = model_decode(raw, gray);
      par_odd = 1'b0;
      for (int i = 0; i < DATA_W; i++) par_odd ^= ((raw >> i) & 1) != 0;
      par_odd ^= par_bit;
      obs_q.delete();
      dv0 = dv_cycles;
      send_frame(raw, gray, stop_bit, par_bit);
      for (int i = 0; i < 4 * CLK_DIV && obs_q.size() == 0; i++) @(posedge clk);
      #1;
      if (obs_q.size() == 0) begin
         check_eq("symbol_timeout", 32'd0, 32'd1);
      end else begin
         o = obs_q.pop_front();
         check_eq("dout", 32'(o[DATA_W-1:0]), 32'(exp_val));
         check_eq("code_err", 32'(o[DATA_W+2]), 32'(exp_val > MAX_CODE));
         check_eq("frame_err", 32'(o[DATA_W+1]), 32'(stop_bit));
         check_eq("par_err", 32'(o[DATA_W]), 32'(PAR_EN & par_odd));
         check_eq("dvalid_one_cycle", 32'(dv_cycles - dv0), 32'd1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_dout"}, 32'(bus.dout), 32'd0);
      check_eq({tag, "_flags"}, {25'd0, bus.dvalid, bus.code_err, bus.frame_err,
                                 bus.par_err, bus.ovr, bus.busy, 1'b0}, 32'd0);
   endtask

   initial begin
      int ovr0;
      int raw;
      bit g, st, p;
      n_checks = 0; n_fail = 0; ovr_cnt = 0; dv_cycles = 0;
      bus.signal = 1'b0; bus.gray_mode = 1'b0; bus.dready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Directed cases from the plan.
      run_symbol(4'b0110, 1'b1, 1'b0, 1'b0);
      run_symbol(4'b1100, 1'b0, 1'b0, 1'b0);
      run_symbol(4'b1101, 1'b1, 1'b0, 1'b1);
      run_symbol(4'b0001, 1'b0, 1'b1, 1'b1);

      // Short glitch: accepted as a start edge, rejected at the half-bit check.
      obs_q.delete();
      bus.signal = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.signal = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("glitch_busy_hi", 32'(bus.busy), 32'd1);
      repeat (CLK_DIV) @(posedge clk);
      #1;
      check_eq("glitch_busy_lo", 32'(bus.busy), 32'd0);
      check_eq("glitch_no_out", 32'(obs_q.size()), 32'd0);

      // Backpressure: second symbol dropped, one overrun pulse.
      bus.dready = 1'b0;
      ovr0 = ovr_cnt;
      send_frame(3, 1'b0, 1'b0, 1'b0);
      check_eq("bp_dvalid", 32'(bus.dvalid), 32'd1);
      check_eq("bp_dout_first", 32'(bus.dout), 32'd3);
      send_frame(5, 1'b0, 1'b0, 1'b0);
      check_eq("bp_dout_held", 32'(bus.dout), 32'd3);
      check_eq("bp_ovr_once", 32'(ovr_cnt - ovr0), 32'd1);
      obs_q.delete();
      bus.dready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_dvalid_drop", 32'(bus.dvalid), 32'd0);
      check_eq("bp_accepted", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() != 0) check_eq("bp_accept_dout", 32'(obs_q[0][DATA_W-1:0]), 32'd3);

      // Reset during data bit 2, then a clean Gray frame.
      bus.gray_mode = 1'b1;
      bus.signal = 1'b1;
      repeat (CLK_DIV) @(posedge clk);
      bus.signal = 1'b0;
      repeat (CLK_DIV) @(posedge clk);
      bus.signal = 1'b1;
      repeat (CLK_DIV / 2 + 2) @(posedge clk);
      #1;
      check_eq("pre_reset_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      bus.signal = 1'b0;
      #2;
      check_all_zero("midframe_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      run_symbol(4'b0111, 1'b1, 1'b0, 1'b0);

      // Randomized symbols against the reference model.
      for (int n = 0; n < 24; n++) begin
         raw = int'($urandom_range(0, (1 << DATA_W) - 1));
         g   = $urandom_range(0, 1) != 0;
         st  = $urandom_range(0, 3) == 0;
         p   = $urandom_range(0, 1) != 0;
         run_symbol(raw, g, st, p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/serial_symbol_decoder.md
Name: serial_symbol_decoder

Overview:
Parametrised successor to the fixed 5-bit digit decoder. Receives framed serial symbols (start bit, DATA_W code bits, optional parity, stop bit) on a single line and samples each bit at mid-bit using an internal baud counter on clk (no derived clock). Decodes each code word as binary or Gray, range-checks it, and presents it on a valid/ready output port with error flags. Sits between the line receiver input pin and the digit/display consumer.

Parameters:
CLK_DIV, 500000, clk cycles per bit period (>=4)
DATA_W, 4, code bits per symbol (2..16)
MAX_CODE, 9, largest legal decoded value; larger values flag code_err
SYNC_STAGES, 2, input synchroniser flops (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
signal  in  1  serial line, idle low, start bit high
gray_mode  in  1  1 = Gray code word, 0 = plain binary; sampled at start-bit confirm
dready  in  1  consumer accepts dout when dvalid=1
dout  out  DATA_W  decoded value, MSB-first
dvalid  out  1  dout/flags valid, held until dready
code_err  out  1  decoded value > MAX_CODE, qualified by dvalid
frame_err  out  1  stop bit sampled high, qualified by dvalid
par_err  out  1  parity mismatch, qualified by dvalid (0 when feature off)
ovr  out  1  one-cycle pulse: symbol completed while dvalid=1 and dready=0
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, counters 0, dout=0, dvalid=0, all flags 0, ovr=0, synchroniser flops 0.
- signal passes through SYNC_STAGES flops; all logic uses synchronised value s.
- IDLE: on s rising (prev 0, now 1) -> START, baud count loaded CLK_DIV/2-1.
- START: at count 0, if s=1 -> DATA, latch gray_mode, bit index 0, reload CLK_DIV-1; if s=0 -> IDLE (glitch reject, no output).
- DATA: sample s at each count 0, shift in MSB-first; after DATA_W samples -> PARITY (feature on) or STOP.
- PARITY: sample one bit; even parity over code bits+parity bit expected.
- STOP: sample one bit; 1 -> frame_err. Then -> IDLE (may re-arm next cycle; s rising detection requires s low first).
- Decode: gray_mode=1 -> b[MSB]=g[MSB], b[i]=b[i+1]^g[i]; else b=raw. code_err = (b > MAX_CODE).
- Output: cycle after stop sample, if dvalid=0 or dready=1: dout<=b, flags updated, dvalid<=1. Else held data/flags kept, new symbol dropped, ovr=1 for one cycle.
- dvalid clears the cycle after dvalid&dready unless a new symbol loads in that same cycle (load wins, dvalid stays 1).
- Latency: stop-bit mid-sample to dvalid = 1 clk.
- Reset mid-frame: immediate return to IDLE, partial symbol discarded.
- Counter width $clog2(CLK_DIV); no wrap beyond terminal count.

Optional Feature:
SERIAL_SYMBOL_PARITY_EN: defined -> PARITY state present, frame = 1+DATA_W+1+1 bits, par_err driven from even-parity check. Undefined -> no parity bit, frame = 1+DATA_W+1 bits, par_err tied 0.

Test Plan:
CLK_DIV=8, DATA_W=4, MAX_CODE=9, parity off, dready=1: gray_mode=1, send 1,0110,0 -> dout=4, dvalid 1 cycle, all errs 0.
gray_mode=0, send 1,1100,0 -> dout=12, code_err=1; gray_mode=1, send 1,1101,0 -> dout=9, code_err=0.
signal high 2 clks then low -> busy drops after half-bit, no dvalid.
send 1,0001,1 -> dout=1, frame_err=1.
dready=0, send two symbols 3 then 5 -> dout stays 3, ovr pulse once; raise dready -> dvalid drops next cycle.
rst_n low during DATA bit 2 -> all outputs 0, next clean frame 1,0111,0 (gray) decodes dout=5; with SERIAL_SYMBOL_PARITY_EN, 1,0111,0(parity),0 -> par_err=1.
